// File: rtl/exe_integer.sv
// Integer ALU execution stage: RV32I register/immediate ALU over two stages
// (E1 operand register, E2 result-queue write) feeding an in-order result
// queue that broadcasts on the CDB when the arbiter grants.
module exe_integer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        kill,
   input  logic        ex_en,
   input  logic [79:0] rs2exe,
   output logic        ready,
   output logic        cdb_req,
   input  logic        cdb_gnt,
   output logic [37:0] cdb_out
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   // Only funct7[5] selects SUB/SRA; the remaining funct7 bits carry no meaning here.
   logic unused_funct7;
   assign unused_funct7 = ^{rs2exe[79], rs2exe[77:73]};

   logic               issue;
   logic               push;
   logic               pop;

   logic               vld_p1;
   logic               alt_p1;
   logic [2:0]         f3_p1;
   logic [5:0]         tag_p1;
   logic [31:0]        opr1_p1;
   logic [31:0]        opr2_p1;
   logic [31:0]        res_p1;

   logic [37:0]        mem_p2 [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   function automatic logic [31:0] alu(input logic        alt,
                                       input logic [2:0]  f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [4:0]         sh;
      logic [31:0]        r;
      sa = a;
      sb = b;
      sh = b[4:0];
      case (f3)
         3'b000:  r = alt ? (a - b) : (a + b);
         3'b001:  r = a << sh;
         3'b010:  r = {31'd0, (sa < sb)};
         3'b011:  r = {31'd0, (a < b)};
         3'b100:  r = a ^ b;
         3'b101:  r = alt ? 32'(sa >>> sh) : (a >> sh);
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // Reserve a queue slot for every instruction already in E1 so an accepted
   // issue can never find the queue full; grant is deliberately not used here.
   assign ready   = (count + CNT_W'(vld_p1)) < FULL;
   assign issue   = ex_en && ready && !kill;
   assign push    = vld_p1 && !kill;
   assign cdb_req = (count != '0) && !kill;
   assign pop     = cdb_req && cdb_gnt;
   assign cdb_out = cdb_req ? mem_p2[rd_ptr] : 38'd0;

   // ---- E1: operand capture ----
   // E1 valid is the only E1 state that needs reset/flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= issue;
   end

   // E1 operands load only on an accepted issue; stale data is masked by vld_p1.
   always_ff @(posedge clk) begin
      if (issue) begin
         alt_p1  <= rs2exe[78];
         f3_p1   <= rs2exe[72:70];
         tag_p1  <= rs2exe[69:64];
         opr1_p1 <= rs2exe[63:32];
         opr2_p1 <= rs2exe[31:0];
      end
   end

   assign res_p1 = alu(alt_p1, f3_p1, opr1_p1, opr2_p1);

   // ---- E2: result queue write ----
   // Queue storage is written at the tail; contents outside count are don't-care.
   always_ff @(posedge clk) begin
      if (push)
         mem_p2[wr_ptr] <= {tag_p1, res_p1};
   end

   // Pointers and occupancy; kill empties the queue and wins over push/pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (kill) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_exe_integer.sv
// Scoreboard bench for exe_integer: expected {tag,result} pushed on accepted
// issue, popped and compared on each granted broadcast.
module tb_exe_integer;

   logic        clk;
   logic        reset_n;
   logic        kill;
   logic        ex_en;
   logic [79:0] rs2exe;
   logic        ready;
   logic        cdb_req;
   logic        cdb_gnt;
   logic [37:0] cdb_out;

   int n_tests = 0;
   int n_fail  = 0;
   int n_bcast = 0;
   int n_acc   = 0;

   logic        obs_req;
   logic        obs_ready;
   logic [37:0] obs_out;

   logic [37:0] sb [$];

   localparam logic [9:0] OP_ADD  = {7'h00, 3'b000};
   localparam logic [9:0] OP_SUB  = {7'h20, 3'b000};
   localparam logic [9:0] OP_SRA  = {7'h20, 3'b101};
   localparam logic [9:0] OP_SLT  = {7'h00, 3'b010};
   localparam logic [9:0] OP_SLTU = {7'h00, 3'b011};

   exe_integer #(.DEPTH(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .kill    (kill),
      .ex_en   (ex_en),
      .rs2exe  (rs2exe),
      .ready   (ready),
      .cdb_req (cdb_req),
      .cdb_gnt (cdb_gnt),
      .cdb_out (cdb_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [9:0] it, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int sh;
      sh = int'(b[4:0]);
      case (it[2:0])
         3'd0: r = it[8] ? a - b : a + b;
         3'd1: r = a << sh;
         3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: r = (a < b) ? 32'd1 : 32'd0;
         3'd4: r = a ^ b;
         3'd5: begin
            r = a >> sh;
            if (it[8] && a[31] && sh != 0)
               r = r | ~(32'hFFFF_FFFF >> sh);
         end
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, observe 1 time unit later,
   // update scoreboard with what the next rising edge will do.
   task automatic step(input logic en, input logic [9:0] it, input logic [5:0] d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic g, input logic k);
      logic [37:0] exp;
      ex_en   = en;
      rs2exe  = {it, d, a, b};
      cdb_gnt = g;
      kill    = k;
      #1;
      obs_req   = cdb_req;
      obs_ready = ready;
      obs_out   = cdb_out;
      if (!cdb_req) chk("idle_out_zero", 64'(cdb_out), 64'd0);
      if (k) chk("kill_req", 64'(cdb_req), 64'd0);
      if (cdb_req && cdb_gnt) begin
         n_bcast++;
         if (sb.size() == 0) chk("spurious_bcast", 64'(cdb_req), 64'd0);
         else begin
            exp = sb.pop_front();
            chk("cdb_out", 64'(cdb_out), 64'(exp));
         end
      end
      if (k) sb.delete();
      else if (en && ready) begin
         sb.push_back({d, model(it, a, b)});
         n_acc++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic g);
      step(1'b0, 10'd0, 6'd0, 32'd0, 32'd0, g, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) idle(1'b1);
      chk("drain_empty", 64'(sb.size()), 64'd0);
      idle(1'b1);
      idle(1'b1);
   endtask

   initial begin
      int acc0;
      int bc0;
      int issued;
      reset_n = 1'b0;
      kill    = 1'b0;
      ex_en   = 1'b0;
      rs2exe  = '0;
      cdb_gnt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_req", 64'(cdb_req), 64'd0);
      chk("rst_out", 64'(cdb_out), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single ADD latency
      step(1'b1, OP_ADD, 6'd3, 32'd5, 32'd7, 1'b1, 1'b0);
      idle(1'b1);
      chk("lat_e1_req", 64'(obs_req), 64'd0);
      idle(1'b1);
      chk("lat_req", 64'(obs_req), 64'd1);
      chk("lat_out", 64'(obs_out), 64'({6'd3, 32'd12}));
      idle(1'b1);
      chk("lat_after", 64'(obs_req), 64'd0);

      // Back-to-back mixed ops, grant held
      step(1'b1, OP_SUB,  6'd1, 32'd0,          32'd1, 1'b1, 1'b0);
      chk("b2b_ready0", 64'(obs_ready), 64'd1);
      step(1'b1, OP_SRA,  6'd2, 32'h8000_0000,  32'd4, 1'b1, 1'b0);
      chk("b2b_ready1", 64'(obs_ready), 64'd1);
      step(1'b1, OP_SLT,  6'd3, 32'hFFFF_FFFF,  32'd1, 1'b1, 1'b0);
      chk("b2b_ready2", 64'(obs_ready), 64'd1);
      step(1'b1, OP_SLTU, 6'd4, 32'hFFFF_FFFF,  32'd1, 1'b1, 1'b0);
      chk("b2b_ready3", 64'(obs_ready), 64'd1);
      idle(1'b1);
      chk("b2b_ready4", 64'(obs_ready), 64'd1);
      drain();

      // Back-pressure with grant held low
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, OP_ADD, 6'(10 + i), 32'(i), 32'd100, 1'b0, 1'b0);
         if (i >= 4) chk("bp_ready_low", 64'(obs_ready), 64'd0);
      end
      chk("bp_accepted", 64'(n_acc - acc0), 64'd4);
      idle(1'b1);
      chk("bp_ready_pop_cycle", 64'(obs_ready), 64'd0);
      idle(1'b1);
      chk("bp_ready_back", 64'(obs_ready), 64'd1);
      drain();

      // Ten issues with toggling grant and pointer wrap
      bc0 = n_bcast;
      issued = 0;
      for (int c = 0; c < 80 && issued < 10; c++) begin
         logic g;
         g = (c >= 4) ? c[0] : 1'b0;
         if (ready) begin
            step(1'b1, {(issued % 2 == 1) ? 7'h20 : 7'h00, 3'(issued)}, 6'(20 + issued),
                 $urandom, $urandom, g, 1'b0);
            issued++;
         end else begin
            idle(g);
         end
      end
      chk("wrap_issued", 64'(issued), 64'd10);
      drain();
      chk("wrap_bcast", 64'(n_bcast - bc0), 64'd10);

      // Kill with two queued and one in E1
      for (int i = 0; i < 3; i++) step(1'b1, OP_ADD, 6'(30 + i), 32'(i), 32'd1, 1'b0, 1'b0);
      step(1'b1, OP_ADD, 6'd40, 32'd9, 32'd9, 1'b1, 1'b1);
      idle(1'b1);
      chk("kill_ready", 64'(obs_ready), 64'd1);
      chk("kill_req_after", 64'(obs_req), 64'd0);
      idle(1'b1);
      idle(1'b1);
      step(1'b1, OP_SUB, 6'd50, 32'd100, 32'd58, 1'b1, 1'b0);
      drain();

      // Async reset mid-operation with three queued
      for (int i = 0; i < 3; i++) step(1'b1, OP_ADD, 6'(60 - i), 32'(i), 32'd2, 1'b0, 1'b0);
      idle(1'b0);
      ex_en = 1'b0;
      cdb_gnt = 1'b0;
      #1;
      chk("pre_rst_req", 64'(cdb_req), 64'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_req", 64'(cdb_req), 64'd0);
      chk("arst_out", 64'(cdb_out), 64'd0);
      chk("arst_ready", 64'(ready), 64'd1);
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
      idle(1'b1);
      step(1'b1, OP_SRA, 6'd7, 32'hF000_0000, 32'd36, 1'b1, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
